branch_predict_controller: RTL and testbench
============================================

# branch_predict_controller

Bimodal branch predictor and misprediction-recovery sequencer for the Buraq-mini RV32IM pipeline. Fetch receives a taken/not-taken prediction from a table of 2-bit saturating counters indexed by PC. Execute reports the resolved outcome from the branch comparator, which trains the table. On a mismatch between prediction and outcome, the block drives a one-cycle fetch redirect to the correct PC and holds a pipeline flush for a fixed number of cycles.

## Interface
- DataWidth, 32: PC and target width.
- Entries, 64: counter table depth; power of two, at least 2.
- IndexLSB, 2: lowest PC bit used in the table index.
- FlushCycles, 2: total cycles `flush` is asserted per misprediction; at least 1.

- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- fetch_valid  input  1  fetch stage presents a valid PC.
- fetch_pc  input  DataWidth  fetch PC to predict.
- pred_taken  output  1  prediction for `fetch_pc`; combinational, `table[idx(fetch_pc)][1] & fetch_valid`.
- ex_valid  input  1  execute stage holds a valid instruction.
- ex_is_branch  input  1  execute instruction is a conditional branch.
- ex_pc  input  DataWidth  PC of the execute-stage branch.
- ex_target  input  DataWidth  computed branch target.
- ex_pred_taken  input  1  prediction issued for this branch, carried down the pipeline.
- ex_taken  input  1  resolved outcome from the branch comparator.
- redirect_valid  output  1  fetch must load `redirect_pc`; registered.
- redirect_pc  output  DataWidth  corrected PC; registered.
- flush  output  1  squash IF/ID/EX contents; registered.
- mispredict_count  output  32  running count of mispredictions.

## Operation
- Index: `idx(pc) = pc[IndexLSB + log2(Entries) - 1 : IndexLSB]`.
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T. The prediction is bit 1.
- Resolve event: `ex_valid & ex_is_branch` while the FSM is in IDLE.
- Training on a resolve event: `table[idx(ex_pc)]` is updated at the clock edge.
  - `ex_taken=1`: increment, saturating at 11.
  - `ex_taken=0`: decrement, saturating at 00.
- Mispredict: a resolve event with `ex_taken != ex_pred_taken`.
- Correct PC on mispredict:
  - `ex_taken=1`: `ex_target`.
  - `ex_taken=0`: `ex_pc + 4`, modulo 2^DataWidth; wraps past the top.
- FSM states:
  - IDLE: outputs `redirect_valid=0`, `flush=0`. A mispredict captures the correct PC into `redirect_pc`, increments `mispredict_count`, and moves to REDIRECT. Otherwise stay in IDLE.
  - REDIRECT: `redirect_valid=1`, `flush=1`. Goes to IDLE if FlushCycles==1, else to DRAIN with the drain counter set to FlushCycles-2.
  - DRAIN: `redirect_valid=0`, `flush=1`. Counter at 0 goes to IDLE; otherwise decrement.
- Outside IDLE, execute inputs are wrong-path: no training, no mispredict detection, no count change.
- A correctly predicted branch trains the table only. It causes no redirect and no flush.
- `mispredict_count` wraps from 0xFFFFFFFF to 0.
- Non-branch instructions and `ex_valid=0` cause no state change.

## Timing
- Reset (async assert, sync deassert assumed upstream):
  - FSM to IDLE.
  - All table entries to 01.
  - `redirect_valid=0`, `redirect_pc=0`, `flush=0`, `mispredict_count=0`.
  - `pred_taken` is 0 after reset for any PC.
- Reset asserted mid-REDIRECT/DRAIN: `flush` and `redirect_valid` drop immediately (asynchronously). No redirect is replayed.
- Prediction latency: 0 cycles (combinational from table flops).
- Lookup and update to the same index in the same cycle: `pred_taken` reflects the pre-update value; there is no bypass. The new value is visible the next cycle.
- Mispredict resolved in cycle N:
  - `redirect_valid` and `flush` are high in cycle N+1.
  - `flush` stays high through cycle N+FlushCycles.
  - The FSM is in IDLE again in cycle N+FlushCycles+1, where a new resolve event is accepted.
- Back-to-back branches: a second branch in cycle N+1..N+FlushCycles is ignored by design, since it is squashed.

## Test plan
- Reset, then `fetch_valid=1`, `fetch_pc=0x100` -> `pred_taken=0`; all outputs 0; `mispredict_count=0`.
- Resolve `ex_pc=0x100`, `ex_taken=1`, `ex_pred_taken=0`, `ex_target=0x80` -> next cycle `redirect_valid=1`, `redirect_pc=0x80`, `flush=1`. `flush` is high exactly 2 cycles, count=1, and `pred_taken` for 0x100 becomes 1 (counter 10).
- Three further correctly predicted taken resolves at 0x100 -> counter saturates at 11, no flush, count unchanged. Then 2 not-taken resolves (the first mispredicted, the second correctly predicted) -> counter 01, prediction 0.
- Not-taken mispredict at `ex_pc=0xFFFFFFFC` -> `redirect_pc=0x00000000`.
- Mispredict immediately followed by another mispredicting branch in the next cycle -> second ignored: one redirect, count +1, second entry untrained.
- Assert `rst_n=0` in the DRAIN state -> `flush=0` without a clock edge. After release, the table reads 01 and `redirect_valid` never pulses.

Source files
------------

// File: rtl/branch_predict_controller.sv
// Bimodal branch predictor with misprediction-recovery sequencer.
// Fetch reads a 2-bit saturating counter per PC index. Execute trains the
// table, and on a misprediction the block issues a one-cycle redirect and
// holds flush for FlushCycles cycles.
module branch_predict_controller #(
    parameter int unsigned DataWidth   = 32,
    parameter int unsigned Entries     = 64,
    parameter int unsigned IndexLSB    = 2,
    parameter int unsigned FlushCycles = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 fetch_valid,
    input  logic [DataWidth-1:0] fetch_pc,
    output logic                 pred_taken,
    input  logic                 ex_valid,
    input  logic                 ex_is_branch,
    input  logic [DataWidth-1:0] ex_pc,
    input  logic [DataWidth-1:0] ex_target,
    input  logic                 ex_pred_taken,
    input  logic                 ex_taken,
    output logic                 redirect_valid,
    output logic [DataWidth-1:0] redirect_pc,
    output logic                 flush,
    output logic [31:0]          mispredict_count
);

    localparam int unsigned IdxW = $clog2(Entries);
    localparam int unsigned CntW = $clog2(FlushCycles + 1);
    // Drain load value; only meaningful when FlushCycles >= 2.
    localparam int unsigned DrainLoad = (FlushCycles > 1) ? FlushCycles - 2 : 0;

    typedef enum logic [1:0] {StIdle, StRedirect, StDrain} state_e;

    state_e               state_q, state_d;
    logic [CntW-1:0]      drain_q, drain_d;
    logic                 redirect_valid_q, redirect_valid_d;
    logic                 flush_q, flush_d;
    logic [DataWidth-1:0] redirect_pc_q, redirect_pc_d;
    logic [31:0]          count_q, count_d;
    logic [1:0]           table_q [Entries];

    logic [IdxW-1:0]      fetch_idx;
    logic [IdxW-1:0]      ex_idx;
    logic                 resolve;
    logic                 mispredict;
    logic [DataWidth-1:0] correct_pc;
    logic [1:0]           ctr_cur;
    logic [1:0]           ctr_next;

    assign fetch_idx = fetch_pc[IndexLSB +: IdxW];
    assign ex_idx    = ex_pc[IndexLSB +: IdxW];

    // No bypass: a same-cycle update to this index shows up next cycle.
    assign pred_taken = table_q[fetch_idx][1] & fetch_valid;

    // Resolve/mispredict decode and saturating counter next value.
    always_comb begin
        resolve    = ex_valid & ex_is_branch & (state_q == StIdle);
        mispredict = resolve & (ex_taken != ex_pred_taken);
        correct_pc = ex_taken ? ex_target : ex_pc + DataWidth'(4);
        ctr_cur    = table_q[ex_idx];
        if (ex_taken) begin
            ctr_next = (ctr_cur == 2'b11) ? 2'b11 : ctr_cur + 2'b01;
        end else begin
            ctr_next = (ctr_cur == 2'b00) ? 2'b00 : ctr_cur - 2'b01;
        end
    end

    // Recovery FSM next state and registered-output next values.
    always_comb begin
        state_d          = state_q;
        drain_d          = drain_q;
        redirect_valid_d = 1'b0;
        flush_d          = 1'b0;
        redirect_pc_d    = redirect_pc_q;
        count_d          = count_q;
        unique case (state_q)
            StIdle: begin
                if (mispredict) begin
                    state_d          = StRedirect;
                    redirect_valid_d = 1'b1;
                    flush_d          = 1'b1;
                    redirect_pc_d    = correct_pc;
                    count_d          = count_q + 32'd1;
                end
            end
            StRedirect: begin
                if (FlushCycles == 1) begin
                    state_d = StIdle;
                end else begin
                    state_d = StDrain;
                    drain_d = CntW'(DrainLoad);
                    flush_d = 1'b1;
                end
            end
            StDrain: begin
                if (drain_q == '0) begin
                    state_d = StIdle;
                end else begin
                    drain_d = drain_q - CntW'(1);
                    flush_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= StIdle;
            drain_q          <= '0;
            redirect_valid_q <= 1'b0;
            flush_q          <= 1'b0;
            redirect_pc_q    <= '0;
            count_q          <= '0;
        end else begin
            state_q          <= state_d;
            drain_q          <= drain_d;
            redirect_valid_q <= redirect_valid_d;
            flush_q          <= flush_d;
            redirect_pc_q    <= redirect_pc_d;
            count_q          <= count_d;
        end
    end

    // Counter table: reset to weak-not-taken, trained only on resolve events.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(Entries); i++) begin
                table_q[i] <= 2'b01;
            end
        end else if (resolve) begin
            table_q[ex_idx] <= ctr_next;
        end
    end

    assign redirect_valid   = redirect_valid_q;
    assign redirect_pc      = redirect_pc_q;
    assign flush            = flush_q;
    assign mispredict_count = count_q;

endmodule

// File: tb/tb_branch_predict_controller.sv
// Self-checking bench for branch_predict_controller with a reference model
// and a scoreboard of expected registered outputs.
module tb_branch_predict_controller;

    localparam int unsigned Fc = 2;

    logic        clk;
    logic        rst_n;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic        pred_taken;
    logic        ex_valid;
    logic        ex_is_branch;
    logic [31:0] ex_pc;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic        ex_taken;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        flush;
    logic [31:0] mispredict_count;

    branch_predict_controller #(
        .DataWidth  (32),
        .Entries    (64),
        .IndexLSB   (2),
        .FlushCycles(Fc)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .fetch_valid     (fetch_valid),
        .fetch_pc        (fetch_pc),
        .pred_taken      (pred_taken),
        .ex_valid        (ex_valid),
        .ex_is_branch    (ex_is_branch),
        .ex_pc           (ex_pc),
        .ex_target       (ex_target),
        .ex_pred_taken   (ex_pred_taken),
        .ex_taken        (ex_taken),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .flush           (flush),
        .mispredict_count(mispredict_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rv;
        logic [31:0] rpc;
        logic        fl;
        logic [31:0] cnt;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state; m_left counts remaining cycles of flush.
    logic [1:0]  m_tab [64];
    int          m_left;
    logic        m_rv;
    logic [31:0] m_rpc;
    logic [31:0] m_cnt;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 64; i++) m_tab[i] = 2'b01;
        m_left = 0;
        m_rv   = 1'b0;
        m_rpc  = 32'h0;
        m_cnt  = 32'h0;
    endtask

    // One cycle: check prediction, advance model, push expectation, clock.
    task automatic step();
        int   idx;
        exp_t e;
        #1;
        idx = int'(fetch_pc[7:2]);
        check_eq("pred_taken", {31'b0, pred_taken}, {31'b0, fetch_valid & m_tab[idx][1]});
        if (m_left == 0 && ex_valid && ex_is_branch) begin
            idx = int'(ex_pc[7:2]);
            if (ex_taken) m_tab[idx] = (m_tab[idx] == 2'b11) ? 2'b11 : m_tab[idx] + 2'b01;
            else          m_tab[idx] = (m_tab[idx] == 2'b00) ? 2'b00 : m_tab[idx] - 2'b01;
            if (ex_taken != ex_pred_taken) begin
                m_left = Fc;
                m_rv   = 1'b1;
                m_rpc  = ex_taken ? ex_target : ex_pc + 32'd4;
                m_cnt  = m_cnt + 32'd1;
            end else begin
                m_rv = 1'b0;
            end
        end else begin
            if (m_left > 0) m_left--;
            m_rv = 1'b0;
        end
        e.rv  = m_rv;
        e.rpc = m_rpc;
        e.fl  = (m_left > 0);
        e.cnt = m_cnt;
        sb_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic resolve(input logic [31:0] pc, input logic [31:0] tgt,
                           input logic pred, input logic taken);
        fetch_valid   = 1'b1;
        fetch_pc      = pc;
        ex_valid      = 1'b1;
        ex_is_branch  = 1'b1;
        ex_pc         = pc;
        ex_target     = tgt;
        ex_pred_taken = pred;
        ex_taken      = taken;
        step();
        ex_valid = 1'b0;
    endtask

    task automatic idle(input int n, input logic [31:0] pc);
        fetch_valid = 1'b1;
        fetch_pc    = pc;
        ex_valid    = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    // Compare registered outputs against the scoreboard on the falling edge.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            check_eq("redirect_valid", {31'b0, redirect_valid}, {31'b0, mon_e.rv});
            check_eq("redirect_pc", redirect_pc, mon_e.rpc);
            check_eq("flush", {31'b0, flush}, {31'b0, mon_e.fl});
            check_eq("mispredict_count", mispredict_count, mon_e.cnt);
        end
    end

    initial begin
        logic [31:0] pcs [4];
        pcs[0] = 32'h100; pcs[1] = 32'h104; pcs[2] = 32'h200; pcs[3] = 32'h300;

        rst_n         = 1'b0;
        fetch_valid   = 1'b0;
        fetch_pc      = 32'h0;
        ex_valid      = 1'b0;
        ex_is_branch  = 1'b0;
        ex_pc         = 32'h0;
        ex_target     = 32'h0;
        ex_pred_taken = 1'b0;
        ex_taken      = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Reset state
        fetch_valid = 1'b1;
        fetch_pc    = 32'h100;
        #1;
        check_eq("rst_pred", {31'b0, pred_taken}, 32'h0);
        check_eq("rst_redirect_valid", {31'b0, redirect_valid}, 32'h0);
        check_eq("rst_redirect_pc", redirect_pc, 32'h0);
        check_eq("rst_flush", {31'b0, flush}, 32'h0);
        check_eq("rst_count", mispredict_count, 32'h0);
        @(negedge clk);

        // Taken mispredict at 0x100 -> redirect to 0x80, counter 10
        resolve(32'h100, 32'h80, 1'b0, 1'b1);
        check_eq("redir_pc_80", redirect_pc, 32'h80);
        idle(3, 32'h100);

        // Three correct taken resolves saturate the counter
        for (int i = 0; i < 3; i++) resolve(32'h100, 32'h80, 1'b1, 1'b1);
        idle(1, 32'h100);
        check_eq("count_after_correct", mispredict_count, 32'd1);

        // Not-taken mispredict then correct not-taken -> counter 01
        resolve(32'h100, 32'h80, 1'b1, 1'b0);
        check_eq("redir_pc_104", redirect_pc, 32'h104);
        idle(2, 32'h100);
        resolve(32'h100, 32'h80, 1'b0, 1'b0);
        idle(1, 32'h100);

        // ex_pc + 4 wraps past the top
        resolve(32'hFFFF_FFFC, 32'h40, 1'b1, 1'b0);
        check_eq("redir_pc_wrap", redirect_pc, 32'h0);
        idle(2, 32'hFFFF_FFFC);

        // Back-to-back mispredicts: second is wrong-path and ignored
        resolve(32'h200, 32'h300, 1'b0, 1'b1);
        resolve(32'h208, 32'h400, 1'b0, 1'b1);
        idle(3, 32'h208);

        // Randomised traffic against the model
        for (int i = 0; i < 60; i++) begin
            fetch_valid   = 1'($urandom_range(0, 1));
            fetch_pc      = pcs[$urandom_range(0, 3)];
            ex_valid      = ($urandom_range(0, 3) != 0);
            ex_is_branch  = ($urandom_range(0, 3) != 0);
            ex_pc         = pcs[$urandom_range(0, 3)];
            ex_target     = $urandom & 32'hFFFF_FFFC;
            ex_pred_taken = 1'($urandom_range(0, 1));
            ex_taken      = 1'($urandom_range(0, 1));
            step();
        end
        idle(3, 32'h100);

        // Reset while in DRAIN: flush drops without a clock edge
        resolve(32'h300, 32'h500, 1'b0, 1'b1);
        idle(1, 32'h300);
        #2;
        check_eq("drain_flush_before_rst", {31'b0, flush}, 32'h1);
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_flush", {31'b0, flush}, 32'h0);
        check_eq("async_rst_redirect", {31'b0, redirect_valid}, 32'h0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle(3, 32'h300);
        idle(1, 32'h100);
        // Table is back at 01: one taken training flips the prediction
        resolve(32'h100, 32'h80, 1'b1, 1'b1);
        idle(2, 32'h100);

        @(negedge clk);
        #1;
        check_eq("scoreboard_empty", sb_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
